nvram_uploader: RTL and testbench



---
 rtl/nvram_uploader.sv | 170 +++++++++++++++++
 tb/tb_nvram_uploader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_uploader.sv
// HPS upload server: turns ioctl byte-read strobes into timed reads of a game-RAM port.
// Optional NVRAM_UPLOAD_PAUSE_EN holds the CPU paused and settles before serving reads.
module nvram_uploader #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         ADDR_W       = 12,
  parameter int         SIZE         = 4096,
  parameter int         RAM_LAT      = 2,
  parameter int         PAUSE_SETTLE = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              cpu_pause,
  output logic              busy
);

  if (RAM_LAT < 1 || RAM_LAT > 7 || PAUSE_SETTLE < 1) begin : g_bad_param
    $error("nvram_uploader: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_FETCH,
    S_OOR
`ifdef NVRAM_UPLOAD_PAUSE_EN
    , S_SETTLE
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rd_q, ram_rd_d;
  logic              busy_q, busy_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              sel, in_range;

`ifdef NVRAM_UPLOAD_PAUSE_EN
  localparam int SET_W = $clog2(PAUSE_SETTLE + 1);
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             pause_q, pause_d;
`endif

  assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign in_range = ioctl_addr < 25'(SIZE);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wait_d     = wait_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    busy_d     = busy_q;
    lat_cnt_d  = lat_cnt_q;
`ifdef NVRAM_UPLOAD_PAUSE_EN
    settle_cnt_d = settle_cnt_q;
    pause_d      = sel;
`endif
    if (!sel) begin
      // Session over (or index changed): drop any in-flight fetch, keep last byte.
      state_d = S_IDLE;
      wait_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b1;
`ifdef NVRAM_UPLOAD_PAUSE_EN
          state_d      = S_SETTLE;
          wait_d       = 1'b1;
          settle_cnt_d = SET_W'(PAUSE_SETTLE - 1);
`else
          state_d = S_READY;
`endif
        end
`ifdef NVRAM_UPLOAD_PAUSE_EN
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = S_READY;
            wait_d  = 1'b0;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
`endif
        S_READY: begin
          if (ioctl_rd) begin
            wait_d = 1'b1;
            if (in_range) begin
              ram_addr_d = ioctl_addr[ADDR_W-1:0];
              ram_rd_d   = 1'b1;
              lat_cnt_d  = 3'(RAM_LAT);
              state_d    = S_FETCH;
            end else begin
              state_d = S_OOR;
            end
          end
        end
        S_FETCH: begin
          // Counter hits zero in the cycle ram_q is valid; capture straight into ioctl_din.
          if (lat_cnt_q == 3'd0) begin
            din_d   = ram_q;
            wait_d  = 1'b0;
            state_d = S_READY;
          end else begin
            lat_cnt_d = lat_cnt_q - 3'd1;
          end
        end
        S_OOR: begin
          din_d   = 8'hFF;
          wait_d  = 1'b0;
          state_d = S_READY;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      lat_cnt_q  <= 3'd0;
`ifdef NVRAM_UPLOAD_PAUSE_EN
      settle_cnt_q <= '0;
      pause_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      busy_q     <= busy_d;
      lat_cnt_q  <= lat_cnt_d;
`ifdef NVRAM_UPLOAD_PAUSE_EN
      settle_cnt_q <= settle_cnt_d;
      pause_q      <= pause_d;
`endif
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign busy       = busy_q;
`ifdef NVRAM_UPLOAD_PAUSE_EN
  assign cpu_pause  = pause_q;
`else
  assign cpu_pause  = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_uploader.sv
// Randomized bench for nvram_uploader: a latency-accurate RAM and a byte-level read model.
`timescale 1ns/1ps
module tb_nvram_uploader;
  localparam logic [7:0] IDX          = 8'd4;
  localparam int         ADDR_W       = 12;
  localparam int         SIZE         = 4096;
  localparam int         RAM_LAT      = 2;
  localparam int         PAUSE_SETTLE = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_upload = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_rd = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              cpu_pause;
  logic              busy;

  logic [7:0]  mem [SIZE];
  logic [7:0]  pd [RAM_LAT];
  logic        pv [RAM_LAT];
  logic [7:0]  junk;
  int          checks = 0;
  int          failures = 0;
  int          rd_count = 0;
  logic [ADDR_W-1:0] last_ram_addr = '0;
  logic [7:0]  exp_din = 8'h00;

  nvram_uploader #(
    .UPLOAD_INDEX(IDX), .ADDR_W(ADDR_W), .SIZE(SIZE),
    .RAM_LAT(RAM_LAT), .PAUSE_SETTLE(PAUSE_SETTLE)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .ram_q(ram_q), .cpu_pause(cpu_pause), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM: data is valid on ram_q exactly RAM_LAT cycles after the ram_rd cycle, junk otherwise.
  always @(posedge clk_sys) begin
    pv[0] <= ram_rd;
    pd[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    junk <= 8'($urandom);
  end
  assign ram_q = (pv[RAM_LAT-1] === 1'b1) ? pd[RAM_LAT-1] : junk;

  always @(negedge clk_sys) begin
    if (ram_rd === 1'b1) begin
      rd_count++;
      last_ram_addr = ram_addr;
    end
  end

  task automatic check_all_zero(input string name);
    checks++;
    if ({ioctl_din, ioctl_wait, ram_addr, ram_rd, cpu_pause, busy} !== '0) begin
      failures++;
      $display("FAIL %s: din=%h wait=%b ram_addr=%h ram_rd=%b pause=%b busy=%b, all must be 0",
               name, ioctl_din, ioctl_wait, ram_addr, ram_rd, cpu_pause, busy);
    end
  endtask

  task automatic start_session();
    int n = 0;
    @(negedge clk_sys);
    ioctl_index = IDX;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_rise: got %b expected 1", busy); end
`ifndef NVRAM_UPLOAD_PAUSE_EN
    checks++;
    if (cpu_pause !== 1'b0) begin failures++; $display("FAIL pause_tied_low: got %b expected 0", cpu_pause); end
`endif
    while (ioctl_wait === 1'b1 && n < 100) begin @(negedge clk_sys); n++; end
    checks++;
    if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL session_ready: wait=%b expected 0", ioctl_wait); end
  endtask

  task automatic end_session();
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask

  // One HPS byte read; expected byte and latency come from the address rules alone.
  task automatic do_read(input logic [24:0] a, input bit poke);
    int lat;
    int rd0;
    int exp_lat;
    bit in_r;
    logic [7:0] exp;
    in_r    = (a < SIZE);
    exp     = in_r ? mem[a[ADDR_W-1:0]] : 8'hFF;
    exp_lat = in_r ? RAM_LAT + 2 : 2;
    rd0     = rd_count;
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    lat = 1;
    checks++;
    if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL wait_cycle1 addr=%h: got %b expected 1", a, ioctl_wait); end
    if (in_r) begin
      checks++;
      if (ram_rd !== 1'b1 || ram_addr !== a[ADDR_W-1:0]) begin
        failures++;
        $display("FAIL ram_strobe addr=%h: ram_rd=%b ram_addr=%h expected 1/%h", a, ram_rd, ram_addr, a[ADDR_W-1:0]);
      end
    end
    while (ioctl_wait === 1'b1 && lat < 64) begin
      if (poke && in_r && lat == 2) begin ioctl_rd = 1'b1; ioctl_addr = a ^ 25'h1; end
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      lat++;
    end
    #1;
    checks++;
    if (lat != exp_lat) begin failures++; $display("FAIL latency addr=%h: got %0d expected %0d", a, lat, exp_lat); end
    checks++;
    if (ioctl_din !== exp) begin failures++; $display("FAIL data addr=%h: got %h expected %h", a, ioctl_din, exp); end
    checks++;
    if (rd_count - rd0 != (in_r ? 1 : 0)) begin
      failures++;
      $display("FAIL ram_rd_count addr=%h: got %0d expected %0d", a, rd_count - rd0, in_r ? 1 : 0);
    end
    exp_din = exp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset_state");
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    start_session();
    do_read(25'h010, 1'b0);
    do_read(25'h1000, 1'b0);
    do_read(25'h1010, 1'b0);
    do_read(25'h1FF_FFFF, 1'b0);
    do_read(25'hFFF, 1'b0);
  endtask

  task automatic test_random();
    logic [24:0] a;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) a = 25'($urandom);
      else a = 25'($urandom_range(0, SIZE - 1));
      do_read(a, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < SIZE; i++) do_read(25'(i), 1'b0);
  endtask

  task automatic test_wrong_index();
    int rd0;
    end_session();
    ioctl_index = 8'd0;
    ioctl_upload = 1'b1;
    rd0 = rd_count;
    for (int i = 0; i < 8; i++) begin
      ioctl_rd = i[0];
      ioctl_addr = 25'($urandom_range(0, SIZE - 1));
      @(negedge clk_sys);
    end
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || ioctl_wait !== 1'b0) begin
      failures++; $display("FAIL wrong_index_busy: busy=%b wait=%b expected 0/0", busy, ioctl_wait);
    end
    checks++;
    if (rd_count != rd0) begin failures++; $display("FAIL wrong_index_ram_rd: got %0d strobes expected 0", rd_count - rd0); end
    checks++;
    if (ioctl_din !== exp_din) begin failures++; $display("FAIL wrong_index_din: got %h expected %h", ioctl_din, exp_din); end
    ioctl_upload = 1'b0;
    start_session();
    @(negedge clk_sys);
    ioctl_index = 8'd5;
    @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL index_change_busy: got %b expected 0", busy); end
    ioctl_upload = 1'b0;
    ioctl_index = IDX;
  endtask

  task automatic test_abort();
    logic [24:0] a;
    start_session();
    do_read(25'h020, 1'b0);
    a = 25'h021;
    mem[a] = ~exp_din;
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b0 || busy !== 1'b0 || ram_rd !== 1'b0) begin
      failures++; $display("FAIL abort_outputs: wait=%b busy=%b ram_rd=%b expected 0/0/0", ioctl_wait, busy, ram_rd);
    end
    repeat (4) @(negedge clk_sys);
    checks++;
    if (ioctl_din !== exp_din) begin failures++; $display("FAIL abort_din_hold: got %h expected %h", ioctl_din, exp_din); end
    start_session();
    checks++;
    if (ioctl_din !== exp_din) begin failures++; $display("FAIL abort_discarded: got %h expected %h", ioctl_din, exp_din); end
    do_read(a, 1'b0);
  endtask

  task automatic test_async_reset();
    start_session();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h033;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_in_fetch");
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_din = 8'h00;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask

`ifdef NVRAM_UPLOAD_PAUSE_EN
  task automatic test_pause();
    int n;
    int rd0;
    end_session();
    ioctl_index = IDX;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (cpu_pause !== 1'b1 || ioctl_wait !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL settle_entry: pause=%b wait=%b busy=%b expected 1/1/1", cpu_pause, ioctl_wait, busy);
    end
    rd0 = rd_count;
    n = 1;
    while (ioctl_wait === 1'b1 && n < 100) begin
      if (n == 3) begin ioctl_rd = 1'b1; ioctl_addr = 25'h010; end
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      n++;
    end
    checks++;
    if (n - 1 != PAUSE_SETTLE) begin failures++; $display("FAIL settle_length: got %0d expected %0d", n - 1, PAUSE_SETTLE); end
    checks++;
    if (rd_count != rd0 || ioctl_din !== exp_din) begin
      failures++; $display("FAIL settle_rd_ignored: strobes=%0d din=%h expected 0/%h", rd_count - rd0, ioctl_din, exp_din);
    end
    checks++;
    if (cpu_pause !== 1'b1) begin failures++; $display("FAIL pause_held: got %b expected 1", cpu_pause); end
    do_read(25'h010, 1'b0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (cpu_pause !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL pause_release: pause=%b busy=%b expected 0/0", cpu_pause, busy);
    end
    ioctl_upload = 1'b1;
    repeat (5) @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_in_settle");
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_din = 8'h00;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask
`endif

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h5A;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_wrong_index();
    test_abort();
    test_async_reset();
`ifdef NVRAM_UPLOAD_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
